i2s_tx: RTL and testbench

- Serializes the stereo parallel sample stream produced at the tail of the effects chain onto a standard I2S link to the output DAC.
- This is the consumer end of the chain's stereo audio_out bus.
- Accepts one stereo sample per frame through a valid/ready handshake and buffers one sample ahead.
- Generates BCLK and LRCLK from the system clock and shifts data MSB-first with the standard one-BCLK delay after each LRCLK edge.

---
 rtl/i2s_tx.sv | 169 ++++++++++++++++
 tb/tb_i2s_tx.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// i2s_tx
// Serializes the stereo sample stream at the end of the effects chain onto
// a standard I2S link feeding the output DAC. A one-deep holding buffer
// takes samples through a valid/ready handshake. The serializer loads a new
// frame from that buffer at every frame boundary.
//
// Ports
//   clk          system clock
//   reset_n      synchronous active-low reset
//   audio_in     stereo sample, [0] = left, [1] = right
//   in_valid     audio_in is valid
//   in_ready     holding buffer is empty and can take a sample
//   enable       run the serializer; when low, BCLK/LRCLK/SDATA stay idle
//   i2s_bclk     bit clock, period 2*BCLK_DIV clk
//   i2s_lrclk    word select, 0 = left slot, 1 = right slot
//   i2s_sdata    serial data, MSB first, one BCLK after each LRCLK edge
//   frame_start  one-cycle pulse when a frame is loaded
//   underrun     one-cycle pulse when a frame loads with the buffer empty
//
// Parameters
//   DATA_W    sample width per channel
//   SLOT_W    BCLK periods per channel slot (>= DATA_W)
//   BCLK_DIV  clk cycles per BCLK half-period (>= 1)

module i2s_tx #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0][DATA_W-1:0] audio_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   enable,
  output logic                   i2s_bclk,
  output logic                   i2s_lrclk,
  output logic                   i2s_sdata,
  output logic                   frame_start,
  output logic                   underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int PAD_W   = SLOT_W - DATA_W;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [1:0][DATA_W-1:0] hold;
  logic                   hold_full;

  logic [DIV_W-1:0]       div_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [FRAME_W-1:0]     shreg;

  logic                   div_last;
  logic                   falling;
  logic                   wrap;
  logic                   accept;
  logic                   load_from_hold;
  logic [BIT_W-1:0]       bit_next;
  logic [FRAME_W-1:0]     frame_word;
  logic [FRAME_W-1:0]     load_word;

  assign in_ready = !hold_full;

  // Event decode. A falling event is the edge where bclk is about to go
  // from 1 to 0; every serial output only moves on those edges so the DAC
  // sees stable data on its rising-edge sample point. The wrap is the
  // falling event that closes the last bit slot of the frame.
  always_comb begin
    div_last       = 1'b0;
    falling        = 1'b0;
    wrap           = 1'b0;
    bit_next       = '0;
    accept         = 1'b0;
    load_from_hold = 1'b0;

    div_last       = (div_cnt == DIV_LAST);
    falling        = enable && div_last && i2s_bclk;
    wrap           = falling && (bit_cnt == LAST_BIT);
    bit_next       = wrap ? '0 : bit_cnt + 1'b1;
    accept         = in_valid && !hold_full;
    load_from_hold = wrap && hold_full;
  end

  // Frame image, left-justified inside each slot: left data, left padding,
  // right data, right padding, with bit FRAME_W-1 going out first. Built
  // with shifts so that SLOT_W == DATA_W (no padding) needs no special case.
  // An empty buffer loads silence.
  always_comb begin
    frame_word = '0;
    load_word  = '0;

    frame_word = (FRAME_W'(hold[0]) << (FRAME_W - DATA_W))
               | (FRAME_W'(hold[1]) << PAD_W);
    load_word  = hold_full ? frame_word : '0;
  end

  // Holding buffer. Since a transfer needs the buffer empty and a load from
  // it needs the buffer full, the two can never fall on the same edge. An
  // accept on the edge of an empty-buffer load therefore lands in the
  // buffer for the following frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= audio_in;
      hold_full <= 1'b1;
    end else if (load_from_hold) begin
      hold_full <= 1'b0;
    end
  end

  // BCLK divider. Dropping enable parks the divider so that a restart
  // always begins with a full low half-period. The first falling event then
  // lands exactly 2*BCLK_DIV clk after enable rises.
  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (div_last) begin
      div_cnt  <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  // Serializer. bit_cnt idles at the last slot so that the first falling
  // event after a restart is a wrap and loads a fresh frame. sdata is taken
  // from the shifter before the load or shift. This delays each word by one
  // BCLK relative to lrclk, and the final bit of a frame leaves on the
  // following wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i2s_lrclk   <= 1'b1;
      i2s_sdata   <= 1'b0;
      bit_cnt     <= LAST_BIT;
      shreg       <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= wrap;
      underrun    <= wrap && !hold_full;

      if (!enable) begin
        i2s_lrclk <= 1'b1;
        i2s_sdata <= 1'b0;
        bit_cnt   <= LAST_BIT;
        shreg     <= '0;
      end else if (falling) begin
        bit_cnt   <= bit_next;
        i2s_lrclk <= (bit_next >= SLOT_LEN);
        i2s_sdata <= shreg[FRAME_W-1];
        if (wrap) begin
          shreg <= load_word;
        end else begin
          shreg <= {shreg[FRAME_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx
// Drives two i2s_tx instances: inst0 with a 16-bit slot and BCLK_DIV=2, and
// inst1 with a 24-bit slot, 16-bit data and BCLK_DIV=3. The bench holds a
// frame-level model of each instance. The model counts clk edges since
// enable and turns that count into the BCLK phase, slot position and
// serial bit by plain arithmetic on a list of loaded frames. All outputs are
// compared every cycle. A small I2S receiver rebuilds words from the serial
// line so that known samples can be checked directly.

module tb_i2s_tx;

  localparam int NI    = 2;
  localparam int DW    = 16;
  localparam int SLOT0 = 16;
  localparam int SLOT1 = 24;
  localparam int DIV0  = 2;
  localparam int DIV1  = 3;
  localparam int NFR   = 64;
  localparam int NRX   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_n;
  logic [1:0][DW-1:0]  audio    [NI];
  logic                in_valid [NI];
  logic                enable   [NI];
  logic                in_ready [NI];
  logic                bclk     [NI];
  logic                lrclk    [NI];
  logic                sdata    [NI];
  logic                fs       [NI];
  logic                ur       [NI];

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      i2s_tx #(
        .DATA_W   (DW),
        .SLOT_W   ((g == 0) ? SLOT0 : SLOT1),
        .BCLK_DIV ((g == 0) ? DIV0 : DIV1)
      ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .audio_in    (audio[g]),
        .in_valid    (in_valid[g]),
        .in_ready    (in_ready[g]),
        .enable      (enable[g]),
        .i2s_bclk    (bclk[g]),
        .i2s_lrclk   (lrclk[g]),
        .i2s_sdata   (sdata[g]),
        .frame_start (fs[g]),
        .underrun    (ur[g])
      );
    end
  endgenerate

  int total;
  int bad;
  int tick_no;

  int                  m_cyc       [NI];
  logic                m_full      [NI];
  logic [1:0][DW-1:0]  m_hold      [NI];
  logic [63:0]         m_frames    [NI][NFR];
  int                  m_nfr       [NI];
  logic                e_fs        [NI];
  logic                e_ur        [NI];

  int                  fs_cnt      [NI];
  int                  ur_cnt      [NI];
  int                  ur_alone    [NI];
  int                  last_fs_tick[NI];

  logic                rx_prev_b   [NI];
  logic                rx_prev_lr  [NI];
  logic                rx_primed   [NI];
  logic [31:0]         rx_acc      [NI];
  logic [31:0]         rx_buf      [NI][NRX];
  int                  rx_n        [NI];

  function automatic int slot_of(int k);
    return (k == 0) ? SLOT0 : SLOT1;
  endfunction

  function automatic int div_of(int k);
    return (k == 0) ? DIV0 : DIV1;
  endfunction

  function automatic logic [63:0] build_frame(int s, logic [1:0][DW-1:0] smp);
    logic [63:0] l;
    logic [63:0] r;
    l = {48'h0, smp[0]};
    r = {48'h0, smp[1]};
    return (l << (2 * s - DW)) | (r << (s - DW));
  endfunction

  // Expected {bclk, lrclk, sdata, in_ready, frame_start, underrun} after
  // the most recent edge, derived from the edge count since enable.
  function automatic logic [5:0] exp_vec(int k);
    int s, d, c, n, fi, j;
    logic b, lr, sd;
    s  = slot_of(k);
    d  = div_of(k);
    c  = m_cyc[k];
    b  = 1'b0;
    lr = 1'b1;
    sd = 1'b0;
    if (c > 0) b = ((c / d) % 2) == 1;
    if (c >= 2 * d) begin
      n  = (c - 2 * d) / (2 * d);
      lr = (n % (2 * s)) >= s;
      if (n > 0) begin
        fi = (n - 1) / (2 * s);
        j  = (n - 1) % (2 * s);
        if (fi < NFR) sd = m_frames[k][fi][2 * s - 1 - j];
      end
    end
    return {b, lr, sd, !m_full[k], e_fs[k], e_ur[k]};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rx_reset(input int k);
    rx_prev_b[k]  = 1'b0;
    rx_prev_lr[k] = 1'b1;
    rx_primed[k]  = 1'b0;
    rx_acc[k]     = '0;
  endtask

  // Model update for one clk edge, using the inputs the DUT sees on it.
  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      int s, d, c;
      logic old_full, consumed;
      s        = slot_of(k);
      d        = div_of(k);
      old_full = m_full[k];
      consumed = 1'b0;
      e_fs[k]  = 1'b0;
      e_ur[k]  = 1'b0;
      if (!reset_n) begin
        m_full[k] = 1'b0;
        m_cyc[k]  = 0;
        m_nfr[k]  = 0;
      end else begin
        if (enable[k]) begin
          m_cyc[k]++;
          c = m_cyc[k];
          if (c >= 2 * d && ((c - 2 * d) % (4 * s * d)) == 0) begin
            if (m_nfr[k] < NFR)
              m_frames[k][m_nfr[k]] = old_full ? build_frame(s, m_hold[k]) : 64'h0;
            m_nfr[k]++;
            e_fs[k]  = 1'b1;
            e_ur[k]  = !old_full;
            consumed = old_full;
          end
        end else begin
          m_cyc[k] = 0;
          m_nfr[k] = 0;
        end
        if (in_valid[k] && !old_full) begin
          m_hold[k] = audio[k];
          m_full[k] = 1'b1;
        end else if (consumed) begin
          m_full[k] = 1'b0;
        end
      end
    end
  endtask

  // One clk cycle: update the model on the edge, then compare and feed the
  // receiver 1 ns later once the DUT registers have settled.
  task automatic tick();
    @(posedge clk);
    model_edge();
    tick_no++;
    #1;
    for (int k = 0; k < NI; k++) begin
      check_output($sformatf("cycle inst%0d", k),
                   64'({bclk[k], lrclk[k], sdata[k], in_ready[k], fs[k], ur[k]}),
                   64'(exp_vec(k)));
      if (fs[k]) begin
        fs_cnt[k]++;
        last_fs_tick[k] = tick_no;
      end
      if (ur[k]) ur_cnt[k]++;
      if (ur[k] && !fs[k]) ur_alone[k]++;
      if (!reset_n || !enable[k]) begin
        rx_reset(k);
      end else begin
        if (bclk[k] && !rx_prev_b[k]) begin
          if (lrclk[k] != rx_prev_lr[k]) begin
            if (rx_primed[k] && rx_n[k] < NRX) begin
              rx_buf[k][rx_n[k]] = (rx_acc[k] << 1) | 32'(sdata[k]);
              rx_n[k]++;
            end
            rx_primed[k] = 1'b1;
            rx_acc[k]    = '0;
          end else begin
            rx_acc[k] = (rx_acc[k] << 1) | 32'(sdata[k]);
          end
          rx_prev_lr[k] = lrclk[k];
        end
        rx_prev_b[k] = bclk[k];
      end
    end
  endtask

  task automatic apply_stimulus(input int k, input logic [1:0][DW-1:0] smp);
    audio[k]    = smp;
    in_valid[k] = 1'b1;
    tick();
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_words(input int k, input int n, input int limit);
    int i;
    i = 0;
    while (rx_n[k] < n && i < limit) begin
      tick();
      i++;
    end
    check_output("word wait", 64'(rx_n[k] >= n), 64'd1);
  endtask

  task automatic clear_counts(input int k);
    fs_cnt[k]   = 0;
    ur_cnt[k]   = 0;
    ur_alone[k] = 0;
    rx_n[k]     = 0;
  endtask

  initial begin
    logic [1:0][DW-1:0] smp_a, smp_b, smp_c, smp_d;
    int   waited, acc_tick, first_nz, nz;
    logic accepted, rdy;

    total   = 0;
    bad     = 0;
    tick_no = 0;
    reset_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      enable[k]       = 1'b0;
      in_valid[k]     = 1'b0;
      audio[k]        = '0;
      m_cyc[k]        = 0;
      m_full[k]       = 1'b0;
      m_hold[k]       = '0;
      m_nfr[k]        = 0;
      e_fs[k]         = 1'b0;
      e_ur[k]         = 1'b0;
      last_fs_tick[k] = 0;
      for (int f = 0; f < NFR; f++) m_frames[k][f] = '0;
      for (int f = 0; f < NRX; f++) rx_buf[k][f] = '0;
      rx_reset(k);
      clear_counts(k);
    end

    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check_output("idle ready", 64'(in_ready[0]), 64'd1);
    check_output("idle bclk", 64'(bclk[0]), 64'd0);
    check_output("idle lrclk", 64'(lrclk[0]), 64'd1);
    check_output("idle sdata", 64'(sdata[0]), 64'd0);

    // Known sample pushed before enable, then read back off the wire.
    $display("[TB] known frame on inst0");
    smp_a = {16'h0F0F, 16'hA5F0};
    apply_stimulus(0, smp_a);
    check_output("held ready", 64'(in_ready[0]), 64'd0);
    clear_counts(0);
    enable[0] = 1'b1;
    wait_words(0, 2, 600);
    check_output("left word", 64'(rx_buf[0][0]), 64'h0000A5F0);
    check_output("right word", 64'(rx_buf[0][1]), 64'h00000F0F);

    // Three frame periods with nothing to send.
    $display("[TB] starved link");
    clear_counts(0);
    repeat (384) tick();
    check_output("underrun count", 64'(ur_cnt[0]), 64'd3);
    check_output("frame count", 64'(fs_cnt[0]), 64'd3);
    check_output("lone underrun", 64'(ur_alone[0]), 64'd0);
    nz = 0;
    for (int i = 0; i < rx_n[0]; i++) if (rx_buf[0][i] != 0) nz++;
    check_output("silence words", 64'(rx_n[0]), 64'd6);
    check_output("silence nonzero", 64'(nz), 64'd0);

    // Backpressure: valid held high across two samples.
    $display("[TB] backpressure");
    smp_a = {16'($urandom), 16'($urandom) | 16'h8000};
    smp_b = {16'($urandom), 16'($urandom)};
    clear_counts(0);
    audio[0]    = smp_a;
    in_valid[0] = 1'b1;
    tick();
    check_output("ready drop", 64'(in_ready[0]), 64'd0);
    audio[0] = smp_b;
    waited   = 0;
    accepted = 1'b0;
    acc_tick = 0;
    while (!accepted && waited < 400) begin
      rdy = in_ready[0];
      tick();
      waited++;
      if (rdy) begin
        accepted = 1'b1;
        acc_tick = tick_no;
      end
    end
    in_valid[0] = 1'b0;
    check_output("second accepted", 64'(accepted), 64'd1);
    check_output("second accept slot", 64'(acc_tick), 64'(last_fs_tick[0] + 1));
    repeat (130) tick();
    check_output("bp underrun", 64'(ur_cnt[0]), 64'd0);
    check_output("bp frames", 64'(fs_cnt[0]), 64'd2);
    repeat (150) tick();
    first_nz = -1;
    for (int i = 0; i < rx_n[0]; i++) if (first_nz < 0 && rx_buf[0][i] != 0) first_nz = i;
    check_output("bp words present", 64'(first_nz >= 0 && first_nz + 3 < rx_n[0]), 64'd1);
    if (first_nz >= 0 && first_nz + 3 < rx_n[0]) begin
      check_output("bp A left", 64'(rx_buf[0][first_nz]), 64'(smp_a[0]));
      check_output("bp A right", 64'(rx_buf[0][first_nz + 1]), 64'(smp_a[1]));
      check_output("bp B left", 64'(rx_buf[0][first_nz + 2]), 64'(smp_b[0]));
      check_output("bp B right", 64'(rx_buf[0][first_nz + 3]), 64'(smp_b[1]));
    end

    // Drop enable in the middle of a left slot with a sample held.
    $display("[TB] enable drop and restart");
    waited = 0;
    while ((tick_no - last_fs_tick[0]) != 20 && waited < 300) begin
      tick();
      waited++;
    end
    smp_c = {16'($urandom), 16'($urandom)};
    apply_stimulus(0, smp_c);
    enable[0] = 1'b0;
    tick();
    check_output("off bclk", 64'(bclk[0]), 64'd0);
    check_output("off lrclk", 64'(lrclk[0]), 64'd1);
    check_output("off sdata", 64'(sdata[0]), 64'd0);
    check_output("off held", 64'(in_ready[0]), 64'd0);
    repeat (10) tick();
    check_output("off still held", 64'(in_ready[0]), 64'd0);
    clear_counts(0);
    enable[0] = 1'b1;
    repeat (10) tick();
    check_output("restart frame", 64'(fs_cnt[0]), 64'd1);
    check_output("restart underrun", 64'(ur_cnt[0]), 64'd0);
    wait_words(0, 2, 300);
    check_output("restart left", 64'(rx_buf[0][0]), 64'(smp_c[0]));
    check_output("restart right", 64'(rx_buf[0][1]), 64'(smp_c[1]));

    // Wide slot with padding on inst1.
    $display("[TB] padded slot on inst1");
    smp_a = {16'h8001, 16'hFFFF};
    apply_stimulus(1, smp_a);
    clear_counts(1);
    enable[1] = 1'b1;
    wait_words(1, 2, 1200);
    check_output("pad left", 64'(rx_buf[1][0]), 64'h00FFFF00);
    check_output("pad right", 64'(rx_buf[1][1]), 64'h00800100);
    enable[1] = 1'b0;
    tick();

    // Reset while running with traffic on the input.
    $display("[TB] reset with traffic");
    smp_d = {16'($urandom), 16'($urandom)};
    audio[0]    = smp_d;
    in_valid[0] = 1'b1;
    tick();
    reset_n = 1'b0;
    tick();
    check_output("rst bclk", 64'(bclk[0]), 64'd0);
    check_output("rst lrclk", 64'(lrclk[0]), 64'd1);
    check_output("rst sdata", 64'(sdata[0]), 64'd0);
    check_output("rst ready", 64'(in_ready[0]), 64'd1);
    check_output("rst frame", 64'(fs[0]), 64'd0);
    check_output("rst underrun", 64'(ur[0]), 64'd0);
    in_valid[0] = 1'b0;
    reset_n     = 1'b1;
    clear_counts(0);
    repeat (10) tick();
    check_output("rst discards hold", 64'(ur_cnt[0]), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
